// File: rtl/div128by64_seq.sv
// Sequential restoring divider: {2*WIDTH} / WIDTH -> WIDTH quotient and remainder, start/done handshake.
// Define DIV128BY64_RADIX4_EN to retire two quotient bits per clock instead of one.
module div128by64_seq #(
  parameter int WIDTH = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero,
  output logic               overflow
);

`ifdef DIV128BY64_RADIX4_EN
  localparam int BPS = 2;
`else
  localparam int BPS = 1;
`endif
  localparam int STEPS = WIDTH / BPS;
  localparam int CW    = $clog2(STEPS + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] part;   // partial remainder; always < divisor between steps
  logic [WIDTH-1:0] shreg;  // unconsumed low dividend bits, MSB first
  logic [WIDTH-1:0] divsr;
  logic [WIDTH-1:0] part_nxt;
  logic [BPS-1:0]   qbits;

  // One restoring step: returns {quotient bit, new partial remainder}.
  function automatic logic [WIDTH:0] step(input logic [WIDTH-1:0] r, input logic b,
                                          input logic [WIDTH-1:0] d);
    logic [WIDTH:0] t;
    logic [WIDTH:0] diff;
    t    = {r, b};
    diff = t - {1'b0, d};
    if (t >= {1'b0, d}) step = {1'b1, diff[WIDTH-1:0]};
    else                step = {1'b0, t[WIDTH-1:0]};
  endfunction

`ifdef DIV128BY64_RADIX4_EN
  logic [WIDTH:0] s1, s2;
  always_comb begin
    s1       = step(part, shreg[WIDTH-1], divsr);
    s2       = step(s1[WIDTH-1:0], shreg[WIDTH-2], divsr);
    qbits    = {s1[WIDTH], s2[WIDTH]};
    part_nxt = s2[WIDTH-1:0];
  end
`else
  logic [WIDTH:0] s1;
  always_comb begin
    s1       = step(part, shreg[WIDTH-1], divsr);
    qbits    = s1[WIDTH];
    part_nxt = s1[WIDTH-1:0];
  end
`endif

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      part        <= '0;
      shreg       <= '0;
      divsr       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          if (divisor == '0) begin
            state       <= S_DONE;
            quotient    <= '1;
            remainder   <= dividend[WIDTH-1:0];
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
          end else if (dividend[2*WIDTH-1:WIDTH] >= divisor) begin
            // quotient would not fit in WIDTH bits
            state       <= S_DONE;
            quotient    <= '1;
            remainder   <= dividend[WIDTH-1:0];
            div_by_zero <= 1'b0;
            overflow    <= 1'b1;
          end else begin
            state       <= S_CALC;
            part        <= dividend[2*WIDTH-1:WIDTH];
            shreg       <= dividend[WIDTH-1:0];
            divsr       <= divisor;
            cnt         <= CW'(STEPS);
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
          end
        end
        S_CALC: begin
          part     <= part_nxt;
          shreg    <= {shreg[WIDTH-BPS-1:0], {BPS{1'b0}}};
          quotient <= {quotient[WIDTH-BPS-1:0], qbits};
          cnt      <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state     <= S_DONE;
            remainder <= part_nxt;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div128by64_seq.sv
// Self-checking bench for div128by64_seq: vector table, corner sequences, random ops vs 128-bit arithmetic model.
module tb_div128by64_seq;
  localparam int W = 64;
`ifdef DIV128BY64_RADIX4_EN
  localparam int LAT_N = W/2 + 1;
`else
  localparam int LAT_N = W + 1;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           start = 1'b0;
  logic [2*W-1:0] dividend = '0;
  logic [W-1:0]   divisor = '0;
  logic           busy, done, div_by_zero, overflow;
  logic [W-1:0]   quotient, remainder;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  div128by64_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  typedef struct {
    logic [2*W-1:0] dvd;
    logic [W-1:0]   dvs;
    logic [W-1:0]   q, r;
    logic           dz, ov;
  } vec_t;

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: plain wide arithmetic plus the error rules.
  function automatic void model(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs,
                                output vec_t e, output int lat);
    logic [2*W-1:0] qq, rr;
    e.dvd = dvd; e.dvs = dvs; e.dz = 1'b0; e.ov = 1'b0; lat = 1;
    if (dvs == '0) begin
      e.dz = 1'b1; e.q = '1; e.r = dvd[W-1:0];
    end else if (dvd[2*W-1:W] >= dvs) begin
      e.ov = 1'b1; e.q = '1; e.r = dvd[W-1:0];
    end else begin
      qq = dvd / {{W{1'b0}}, dvs};
      rr = dvd % {{W{1'b0}}, dvs};
      e.q = qq[W-1:0]; e.r = rr[W-1:0]; lat = LAT_N;
    end
  endfunction

  task automatic launch(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs);
    @(negedge clk);
    start = 1'b1; dividend = dvd; divisor = dvs;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(inout int lat);
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input vec_t e, input int lat, input int exp_lat);
    chk({tag, ".lat"}, 128'(lat), 128'(exp_lat));
    chk({tag, ".q"}, 128'(quotient), 128'(e.q));
    chk({tag, ".r"}, 128'(remainder), 128'(e.r));
    chk({tag, ".dz"}, 128'(div_by_zero), 128'(e.dz));
    chk({tag, ".ov"}, 128'(overflow), 128'(e.ov));
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, 128'(done), 128'(0));
    chk({tag, ".idle"}, 128'(busy), 128'(0));
  endtask

  task automatic run_vec(input string tag, input vec_t e, input int exp_lat);
    int lat;
    launch(e.dvd, e.dvs);
    chk({tag, ".busy1"}, 128'(busy), 128'(1));
    lat = 1;
    wait_done(lat);
    check_result(tag, e, lat, exp_lat);
  endtask

  initial begin
    vec_t tbl[7];
    vec_t e, e2;
    int lat, elat;
    logic [2*W-1:0] prod;

    prod = 128'(64'd264809178) * 128'(64'd249197382);
    tbl[0] = '{128'd100, 64'd7, 64'd14, 64'd2, 1'b0, 1'b0};
    tbl[1] = '{{64'd1, 64'd0}, 64'd3, 64'h5555555555555555, 64'd1, 1'b0, 1'b0};
    tbl[2] = '{prod, 64'd249197382, 64'd264809178, 64'd0, 1'b0, 1'b0};
    tbl[3] = '{128'h1234, 64'd0, '1, 64'h1234, 1'b1, 1'b0};
    tbl[4] = '{{64'd5, 64'hABCD}, 64'd5, '1, 64'hABCD, 1'b0, 1'b1};
    tbl[5] = '{{64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF}, '1, '1,
               64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    tbl[6] = '{128'd0, 64'd1, 64'd0, 64'd0, 1'b0, 1'b0};

    // asynchronous reset, checked before any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("rst.q", 128'(quotient), 0);
    chk("rst.r", 128'(remainder), 0);
    chk("rst.flags", 128'({busy, done, div_by_zero, overflow}), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      elat = (tbl[i].dz || tbl[i].ov) ? 1 : LAT_N;
      run_vec($sformatf("vec%0d", i), tbl[i], elat);
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("vec%0d.held_q", i), 128'(quotient), 128'(tbl[i].q));
      chk($sformatf("vec%0d.held_r", i), 128'(remainder), 128'(tbl[i].r));
      chk($sformatf("vec%0d.held_fl", i), 128'({div_by_zero, overflow}), 128'({tbl[i].dz, tbl[i].ov}));
    end

    // start pulsed during an active op must be ignored
    model({64'h0123_4567_89AB_CDEF, 64'h0F1E_2D3C_4B5A_6978}, 64'hFEDC_BA98_7654_3210, e, elat);
    launch(e.dvd, e.dvs);
    lat = 1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    start = 1'b1; dividend = 128'd999; divisor = 64'd10;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 10;
    wait_done(lat);
    check_result("ignore_start", e, lat, elat);

    // reset in the middle of CALC aborts the op
    launch({64'h0123_4567_89AB_CDEF, 64'hFFFF_0000_FFFF_0000}, 64'hFEDC_BA98_7654_3210);
    repeat (29) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst.q", 128'(quotient), 0);
    chk("midrst.r", 128'(remainder), 0);
    chk("midrst.flags", 128'({busy, done, div_by_zero, overflow}), 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("midrst.no_done", 128'(done), 0);
    end
    @(negedge clk) rst_n = 1'b1;
    run_vec("after_rst", tbl[0], LAT_N);

    // randomized ops, mixing normal, overflow and divide-by-zero
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] hi, lo, dv;
      int mode;
      mode = $urandom_range(0, 9);
      dv = {$urandom, $urandom} >> $urandom_range(0, 60);
      hi = {$urandom, $urandom};
      lo = {$urandom, $urandom};
      if (mode == 0) dv = '0;
      else if (dv == '0) dv = 64'd1;
      if (mode > 1 && dv != '0) hi = hi % dv;
      model({hi, lo}, dv, e2, elat);
      run_vec($sformatf("rnd%0d", n), e2, elat);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
